wvb_rr_arbiter: RTL and testbench

- Parametrised N-channel readout arbiter between the per-channel waveform buffers and a single downstream consumer (secondary buffer fill path or wvb_reader).
- Locks onto one channel with a non-empty header FIFO and routes the consumer's hdr_rdreq/wvb_rdreq/wvb_rddone handshake to that channel only. Presents that channel's data with its index.
- Successor to the fixed 24-channel selection: adds runtime round-robin vs fixed-priority modes, a per-channel enable mask and generic channel/data/header widths.

---
 rtl/wvb_rr_arbiter_pkg.sv | 19 +
 rtl/wvb_rr_arbiter_select.sv | 42 ++++
 rtl/wvb_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_wvb_rr_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wvb_rr_arbiter_pkg.sv
// Shared constants, state encoding and counter helper for the waveform-buffer readout arbiter.
package wvb_rr_arbiter_pkg;

   localparam logic L_ARB_MODE_RR         = 1'b0;
   localparam logic L_ARB_MODE_PRIO       = 1'b1;
   localparam int   L_WIDTH_ARB_STATS_CNT = 16;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   function automatic logic [L_WIDTH_ARB_STATS_CNT-1:0] sat_inc(
      input logic [L_WIDTH_ARB_STATS_CNT-1:0] value
   );
      return (&value) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/wvb_rr_arbiter_select.sv
// Rotate-and-priority-encode: picks the first requester after rr_ptr (round-robin) or the lowest index.
module wvb_arb_select
   import wvb_rr_arbiter_pkg::*;
#(
   parameter int N_CHANNELS  = 24,
   parameter int P_IDX_WIDTH = 5
) (
   input  logic [N_CHANNELS-1:0]  req,
   input  logic [P_IDX_WIDTH-1:0] rr_ptr,
   input  logic                   mode,
   output logic                   valid,
   output logic [P_IDX_WIDTH-1:0] idx
);

   int                    start_s;
   int                    pos_s;
   logic [N_CHANNELS-1:0] rot_s;

   // Rotate req so the search origin sits at bit 0, then take the lowest set bit.
   always_comb begin
      start_s = 32'sd0;
      pos_s   = 32'sd0;
      valid   = 1'b0;
      if (mode == L_ARB_MODE_RR && int'(rr_ptr) < N_CHANNELS - 1) begin
         start_s = int'(rr_ptr) + 32'sd1;
      end else begin
         start_s = 32'sd0;
      end
      rot_s = N_CHANNELS'({req, req} >> start_s);
      for (int i = N_CHANNELS - 1; i >= 0; i--) begin
         valid = valid | rot_s[i];
         pos_s = rot_s[i] ? start_s + i : pos_s;
      end
      if (pos_s >= N_CHANNELS) begin
         pos_s = pos_s - N_CHANNELS;
      end else begin
         pos_s = pos_s;
      end
      idx = P_IDX_WIDTH'(pos_s);
   end

endmodule

// File: rtl/wvb_rr_arbiter.sv
// N-channel waveform-buffer readout arbiter with round-robin / fixed-priority selection.
// Optional per-channel grant counters are built when SCDB_ARB_STATS_EN is defined.
module wvb_rr_arbiter
   import wvb_rr_arbiter_pkg::*;
#(
   parameter int N_CHANNELS   = 24,
   parameter int P_DATA_WIDTH = 170,
   parameter int P_HDR_WIDTH  = 113,
   parameter int P_IDX_WIDTH  = 5
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             en,
   input  logic                             arb_mode,
   input  logic [N_CHANNELS-1:0]            chan_en,
   input  logic [N_CHANNELS-1:0]            wvb_hdr_empty,
   input  logic [N_CHANNELS*P_HDR_WIDTH-1:0]  wvb_hdr_data,
   input  logic [N_CHANNELS*P_DATA_WIDTH-1:0] wvb_data,
   output logic [N_CHANNELS-1:0]            wvb_hdr_rdreq,
   output logic [N_CHANNELS-1:0]            wvb_rdreq,
   output logic [N_CHANNELS-1:0]            wvb_rddone,
   output logic                             hdr_empty,
   output logic [P_HDR_WIDTH-1:0]           hdr_data,
   output logic [P_DATA_WIDTH-1:0]          data_out,
   output logic [P_IDX_WIDTH-1:0]           chan_idx,
   output logic                             busy,
   input  logic                             hdr_rdreq,
   input  logic                             rdreq,
   input  logic                             rddone,
   input  logic [P_IDX_WIDTH-1:0]           stats_sel,
   input  logic                             stats_clr,
   output logic [L_WIDTH_ARB_STATS_CNT-1:0] stats_cnt
);

   arb_state_t             state_r;
   logic [P_IDX_WIDTH-1:0] chan_idx_r;
   logic [P_IDX_WIDTH-1:0] rr_ptr_r;
   logic                   busy_r;
   logic [N_CHANNELS-1:0]  req_s;
   logic                   grant_valid_s;
   logic [P_IDX_WIDTH-1:0] grant_idx_s;
   logic                   grant_fire_s;
   logic                   locked_s;
   logic [N_CHANNELS-1:0]  idx_hit_s;
   logic [N_CHANNELS-1:0]  route_s;

   assign req_s        = ~wvb_hdr_empty & chan_en;
   assign grant_fire_s = (state_r == ST_IDLE) && en && grant_valid_s;
   assign locked_s     = (state_r == ST_LOCKED);

   wvb_arb_select #(
      .N_CHANNELS  (N_CHANNELS),
      .P_IDX_WIDTH (P_IDX_WIDTH)
   ) u_select (
      .req    (req_s),
      .rr_ptr (rr_ptr_r),
      .mode   (arb_mode),
      .valid  (grant_valid_s),
      .idx    (grant_idx_s)
   );

   // Lock/release state machine; rr_ptr follows every grant in both modes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         chan_idx_r <= '0;
         busy_r     <= 1'b0;
         rr_ptr_r   <= P_IDX_WIDTH'(N_CHANNELS - 1);
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_fire_s) begin
                  state_r    <= ST_LOCKED;
                  chan_idx_r <= grant_idx_s;
                  rr_ptr_r   <= grant_idx_s;
                  busy_r     <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (rddone) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < N_CHANNELS; i++) begin : g_hit
      assign idx_hit_s[i] = (chan_idx_r == P_IDX_WIDTH'(i));
   end

   // Handshake only reaches the locked channel; anything arriving in IDLE is dropped.
   assign route_s       = idx_hit_s & {N_CHANNELS{locked_s}};
   assign wvb_hdr_rdreq = route_s & {N_CHANNELS{hdr_rdreq}};
   assign wvb_rdreq     = route_s & {N_CHANNELS{rdreq}};
   assign wvb_rddone    = route_s & {N_CHANNELS{rddone}};
   assign hdr_empty     = locked_s ? |(idx_hit_s & wvb_hdr_empty) : 1'b1;
   assign chan_idx      = chan_idx_r;
   assign busy          = busy_r;

   // AND-OR data mux keyed on the registered channel index.
   always_comb begin
      hdr_data = '0;
      data_out = '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
         hdr_data = hdr_data | (wvb_hdr_data[i*P_HDR_WIDTH +: P_HDR_WIDTH] & {P_HDR_WIDTH{idx_hit_s[i]}});
         data_out = data_out | (wvb_data[i*P_DATA_WIDTH +: P_DATA_WIDTH] & {P_DATA_WIDTH{idx_hit_s[i]}});
      end
   end

`ifdef SCDB_ARB_STATS_EN
   logic [L_WIDTH_ARB_STATS_CNT-1:0] cnt_r [N_CHANNELS];
   logic [L_WIDTH_ARB_STATS_CNT-1:0] cnt_sel_s;
   logic [L_WIDTH_ARB_STATS_CNT-1:0] stats_cnt_r;

   // Counter readback select.
   always_comb begin
      cnt_sel_s = '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
         cnt_sel_s = cnt_sel_s | (cnt_r[i] & {L_WIDTH_ARB_STATS_CNT{stats_sel == P_IDX_WIDTH'(i)}});
      end
   end

   // Saturating grant counters; a clear coinciding with a grant wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stats_cnt_r <= '0;
         for (int i = 0; i < N_CHANNELS; i++) begin
            cnt_r[i] <= '0;
         end
      end else begin
         stats_cnt_r <= cnt_sel_s;
         for (int i = 0; i < N_CHANNELS; i++) begin
            if (stats_clr) begin
               cnt_r[i] <= '0;
            end else if (grant_fire_s && grant_idx_s == P_IDX_WIDTH'(i)) begin
               cnt_r[i] <= sat_inc(cnt_r[i]);
            end
         end
      end
   end

   assign stats_cnt = stats_cnt_r;
`else
   logic stats_unused_s;
   assign stats_unused_s = ^{stats_sel, stats_clr};
   assign stats_cnt      = '0;
`endif

endmodule

// File: tb/tb_wvb_rr_arbiter.sv
// Directed bench for wvb_rr_arbiter: reset, latency, routing, arbitration table and corner sequences.
module tb_wvb_rr_arbiter;

   localparam int N  = 24;
   localparam int HW = 113;
   localparam int DW = 170;
   localparam int IW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          arb_mode;
   logic [N-1:0]  chan_en;
   logic [N-1:0]  wvb_hdr_empty;
   logic [N*HW-1:0] wvb_hdr_data;
   logic [N*DW-1:0] wvb_data;
   logic [N-1:0]  wvb_hdr_rdreq;
   logic [N-1:0]  wvb_rdreq;
   logic [N-1:0]  wvb_rddone;
   logic          hdr_empty;
   logic [HW-1:0] hdr_data;
   logic [DW-1:0] data_out;
   logic [IW-1:0] chan_idx;
   logic          busy;
   logic          hdr_rdreq;
   logic          rdreq;
   logic          rddone;
   logic [IW-1:0] stats_sel;
   logic          stats_clr;
   logic [15:0]   stats_cnt;

   int checks = 0;
   int errors = 0;
   int g5     = 0;

   typedef struct {
      logic         mode;
      logic [N-1:0] chen;
      logic [N-1:0] req;
      int           exp;
   } vec_t;

   vec_t vecs [14];

   always #5 clk = ~clk;

   wvb_rr_arbiter #(
      .N_CHANNELS   (N),
      .P_DATA_WIDTH (DW),
      .P_HDR_WIDTH  (HW),
      .P_IDX_WIDTH  (IW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .arb_mode      (arb_mode),
      .chan_en       (chan_en),
      .wvb_hdr_empty (wvb_hdr_empty),
      .wvb_hdr_data  (wvb_hdr_data),
      .wvb_data      (wvb_data),
      .wvb_hdr_rdreq (wvb_hdr_rdreq),
      .wvb_rdreq     (wvb_rdreq),
      .wvb_rddone    (wvb_rddone),
      .hdr_empty     (hdr_empty),
      .hdr_data      (hdr_data),
      .data_out      (data_out),
      .chan_idx      (chan_idx),
      .busy          (busy),
      .hdr_rdreq     (hdr_rdreq),
      .rdreq         (rdreq),
      .rddone        (rddone),
      .stats_sel     (stats_sel),
      .stats_clr     (stats_clr),
      .stats_cnt     (stats_cnt)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Waits (bounded) for a grant from IDLE, checks the granted channel.
   task automatic wait_grant(input string name, input int exp);
      bit got = 1'b0;
      for (int c = 0; c < 4 && !got; c++) begin
         @(negedge clk);
         #1;
         got = busy;
      end
      check({name, " busy"}, {255'd0, got}, 256'd1);
      check({name, " chan_idx"}, 256'(chan_idx), 256'(exp));
      check({name, " hdr_data"}, 256'(hdr_data), 256'(HW'(32'hA000 + exp)));
      if (exp == 5) g5++;
   endtask

   task automatic release_lock(input string name, input int exp);
      rddone = 1'b1;
      #1;
      check({name, " rddone route"}, 256'(wvb_rddone), 256'(24'd1 << exp));
      @(negedge clk);
      rddone = 1'b0;
      #1;
      check({name, " released"}, {255'd0, busy}, 256'd0);
   endtask

   initial begin
      vecs[0]  = '{1'b0, {N{1'b1}}, (24'd1 << 5) | (24'd1 << 23), 5};
      vecs[1]  = '{1'b0, {N{1'b1}}, (24'd1 << 5) | (24'd1 << 23), 23};
      vecs[2]  = '{1'b0, {N{1'b1}}, (24'd1 << 5) | (24'd1 << 23), 5};
      vecs[3]  = '{1'b0, {N{1'b1}}, (24'd1 << 5) | (24'd1 << 23), 23};
      vecs[4]  = '{1'b1, {N{1'b1}}, (24'd1 << 5) | (24'd1 << 23), 5};
      vecs[5]  = '{1'b1, {N{1'b1}}, (24'd1 << 5) | (24'd1 << 23), 5};
      vecs[6]  = '{1'b1, {N{1'b1}}, (24'd1 << 5) | (24'd1 << 23), 5};
      vecs[7]  = '{1'b0, {N{1'b1}}, (24'd1 << 5) | (24'd1 << 23), 23};
      vecs[8]  = '{1'b0, {N{1'b1}}, 24'd1 | (24'd1 << 5) | (24'd1 << 23), 0};
      vecs[9]  = '{1'b0, {N{1'b1}}, 24'd1, 0};
      vecs[10] = '{1'b0, ~24'd1, 24'd1 | (24'd1 << 5) | (24'd1 << 23), 5};
      vecs[11] = '{1'b1, {N{1'b1}}, (24'd1 << 3) | (24'd1 << 10), 3};
      vecs[12] = '{1'b0, {N{1'b1}}, (24'd1 << 3) | (24'd1 << 10), 10};
      vecs[13] = '{1'b0, {N{1'b1}}, (24'd1 << 3) | (24'd1 << 9), 3};

      for (int i = 0; i < N; i++) begin
         wvb_hdr_data[i*HW +: HW] = HW'(32'hA000 + i);
         wvb_data[i*DW +: DW]     = DW'(32'hD000 + i);
      end
      rst_n = 1'b0; en = 1'b0; arb_mode = 1'b0; chan_en = {N{1'b1}};
      wvb_hdr_empty = {N{1'b1}}; hdr_rdreq = 1'b0; rdreq = 1'b0; rddone = 1'b0;
      stats_sel = 5'd5; stats_clr = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      check("reset busy", {255'd0, busy}, 256'd0);
      check("reset hdr_empty", {255'd0, hdr_empty}, 256'd1);
      check("reset chan_idx", 256'(chan_idx), 256'd0);
      check("reset onehot", 256'({wvb_hdr_rdreq, wvb_rdreq, wvb_rddone}), 256'd0);
      check("reset stats", 256'(stats_cnt), 256'd0);

      // Only channel 23 has data; requests in IDLE must be dropped.
      rst_n = 1'b1;
      wvb_hdr_empty = ~(24'd1 << 23);
      hdr_rdreq = 1'b1; rdreq = 1'b1; rddone = 1'b1;
      #1;
      check("idle drop", 256'({wvb_hdr_rdreq, wvb_rdreq, wvb_rddone}), 256'd0);
      @(negedge clk);
      #1;
      check("en low no grant", {255'd0, busy}, 256'd0);
      hdr_rdreq = 1'b0; rdreq = 1'b0; rddone = 1'b0; en = 1'b1;
      #1;
      check("latency cycle n", {255'd0, hdr_empty}, 256'd1);
      @(negedge clk);
      #1;
      check("latency cycle n+1", {255'd0, hdr_empty}, 256'd0);
      check("first chan_idx", 256'(chan_idx), 256'd23);
      check("first data_out", 256'(data_out), 256'(DW'(32'hD017)));
      hdr_rdreq = 1'b1;
      #1;
      check("hdr_rdreq route", 256'(wvb_hdr_rdreq), 256'(24'd1 << 23));
      @(negedge clk);
      hdr_rdreq = 1'b0; rdreq = 1'b1;
      #1;
      check("rdreq route", 256'({wvb_hdr_rdreq, wvb_rdreq}), 256'(24'd1 << 23));
      @(negedge clk);
      rdreq = 1'b0;
      release_lock("first", 23);
      check("idle hdr_empty", {255'd0, hdr_empty}, 256'd1);

      for (int v = 0; v < 14; v++) begin
         arb_mode = vecs[v].mode;
         chan_en = vecs[v].chen;
         wvb_hdr_empty = ~vecs[v].req;
         wait_grant($sformatf("vec%0d", v), vecs[v].exp);
         release_lock($sformatf("vec%0d", v), vecs[v].exp);
      end

      // Mask and enable dropped while locked: lock holds until rddone.
      arb_mode = 1'b0; chan_en = {N{1'b1}};
      wvb_hdr_empty = ~((24'd1 << 5) | (24'd1 << 23));
      wait_grant("mask lock", 5);
      chan_en = ~(24'd1 << 5); en = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("mask hold busy", {255'd0, busy}, 256'd1);
      check("mask hold idx", 256'(chan_idx), 256'd5);
      en = 1'b1;
      release_lock("mask", 5);
      wait_grant("mask next", 23);

      // Grant counters (held while locked on 23, so no further grants).
      @(negedge clk);
      #1;
`ifdef SCDB_ARB_STATS_EN
      check("stats ch5", 256'(stats_cnt), 256'(g5));
`else
      check("stats ch5", 256'(stats_cnt), 256'd0);
`endif
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      @(negedge clk);
      #1;
      check("stats cleared", 256'(stats_cnt), 256'd0);

      // Async reset mid-transfer.
      rdreq = 1'b1;
      #1;
      check("pre-reset rdreq", 256'(wvb_rdreq), 256'(24'd1 << 23));
      rst_n = 1'b0;
      #1;
      check("async busy", {255'd0, busy}, 256'd0);
      check("async rdreq", 256'(wvb_rdreq), 256'd0);
      rdreq = 1'b0;
      wvb_hdr_empty = ~(24'd1 | (24'd1 << 5));
      @(negedge clk);
      rst_n = 1'b1;
      wait_grant("post reset", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
